// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_tx_serializer_pkg
// Description : Shared definitions for the UART transmit serializer. Holds
//               the FSM state encoding, the parity-mode constants and a
//               helper that computes the parity bit for a data word.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_serializer_pkg;

    // Widest legal data word; the parity helper works on this width.
    localparam int MAX_DATA_BITS = 9;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Serializer FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    // Parity bit for a zero-extended data word. Even parity makes the total
    // count of ones (data + parity) even; odd parity makes it odd.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     even);
        return even ? (^data) : (~^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Accepts parallel words on a
//               valid/ready handshake into a 1-entry holding register,
//               enables an external baud generator and shifts frames out
//               LSB first: start, data, optional parity, stop bit(s).
//               Frames are sent back-to-back with no idle gap whenever the
//               holding register is full at the end of a frame.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               tx_data    - word to send, captured on valid && ready
//               tx_valid   - upstream has a word
//               tx_ready   - holding register empty
//               baud_tick  - one-clock pulse per bit period from baudgen_tx
//               baud_en    - registered enable to baudgen_tx
//               txd        - registered serial line, idles high
//               tx_busy    - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 txd_q;
    logic                 baud_en_q;

    logic                 w_accept;
    logic                 w_par;

    // Accept only into an empty holding register; a load always empties it,
    // so accept and load can never coincide.
    assign w_accept = tx_valid && !hold_full_q;
    assign w_par    = parity_bit(MAX_DATA_BITS'(hold_q), PARITY == PARITY_EVEN);

    assign tx_ready = !hold_full_q;
    assign txd      = txd_q;
    assign baud_en  = baud_en_q;
    assign tx_busy  = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            txd_q       <= 1'b1;
            baud_en_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    txd_q     <= 1'b1;
                    baud_en_q <= 1'b0;
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
                        par_q       <= w_par;
                        hold_full_q <= 1'b0;
                        baud_en_q   <= 1'b1;
                        state_q     <= ST_ARM;
                    end
                end

                // Wait for the first tick so the start bit spans a full
                // baud period.
                ST_ARM: begin
                    txd_q <= 1'b1;
                    if (baud_tick) begin
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_tick) begin
                        txd_q     <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            if (PARITY != PARITY_NONE) begin
                                txd_q   <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                txd_q      <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= ST_STOP;
                            end
                        end else begin
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (baud_tick) begin
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            if (hold_full_q) begin
                                // Next word waiting: start bit follows the
                                // last stop bit directly, baud_en stays high.
                                shift_q     <= hold_q;
                                par_q       <= w_par;
                                hold_full_q <= 1'b0;
                                txd_q       <= 1'b0;
                                state_q     <= ST_START;
                            end else begin
                                baud_en_q <= 1'b0;
                                state_q   <= ST_IDLE;
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    txd_q     <= 1'b1;
                    baud_en_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
